// File: rtl/led_flash_multi.sv
// led_flash_multi
//   Multi-channel LED activity driver. Every channel runs its own small FSM in
//   one of four modes: off, stretch (stay lit for a while after activity),
//   blink while active, or a one-shot pulse started by a rising edge. The hold
//   length and the blink half-period are shared by all channels.
//
// Ports
//   clock       in   1           system clock, all logic on posedge
//   reset       in   1           synchronous, active-high
//   signal      in   CHANNELS    per-channel activity input
//   mode        in   2*CHANNELS  ch n = mode[2n+1:2n]; 00 off, 01 stretch, 10 blink, 11 pulse
//   period      in   CNT_W       hold/pulse length (lit for period+1 clocks)
//   blink_half  in   CNT_W       blink half-period (each half is blink_half+1 clocks)
//   LED         out  CHANNELS    LED pins, LED[n] = lit[n] ^ ACTIVE_LOW

// One channel: FSM, counter and the lit flop.
module led_flash_chan #(
    parameter int CNT_W = 25
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             signal,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] blink_half,
    output logic             lit
);
    typedef enum logic [1:0] {IDLE, ACTIVE, HOLD} state_t;

    localparam logic [1:0] MODE_OFF     = 2'b00;
    localparam logic [1:0] MODE_STRETCH = 2'b01;
    localparam logic [1:0] MODE_BLINK   = 2'b10;
    localparam logic [1:0] MODE_PULSE   = 2'b11;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lit_q, lit_d;
    logic             sig_q, sig_d;
    logic [1:0]       mode_q, mode_d;

    logic [CNT_W-1:0] cnt_inc;
    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lit_d   = lit_q;
        sig_d   = signal;
        mode_d  = mode_q;

        if (mode != mode_q) begin
            // A mode change always spends one cycle dark in IDLE.
            mode_d  = mode;
            state_d = IDLE;
            lit_d   = 1'b0;
            cnt_d   = '0;
        end else begin
            case (mode)
                MODE_OFF: begin
                    state_d = IDLE;
                    lit_d   = 1'b0;
                    cnt_d   = '0;
                end
                MODE_STRETCH, MODE_BLINK: begin
                    if (signal) begin
                        if (mode == MODE_BLINK && state_q == ACTIVE) begin
                            if (cnt_q == blink_half) begin
                                lit_d = ~lit_q;
                                cnt_d = '0;
                            end else begin
                                cnt_d = cnt_inc;
                            end
                        end else begin
                            state_d = ACTIVE;
                            lit_d   = 1'b1;
                            cnt_d   = '0;
                        end
                    end else if (state_q == ACTIVE) begin
                        // Blink goes solid for the hold phase.
                        state_d = HOLD;
                        lit_d   = 1'b1;
                        cnt_d   = '0;
                    end else if (state_q == HOLD) begin
                        if (cnt_q == period) begin
                            state_d = IDLE;
                            lit_d   = 1'b0;
                            cnt_d   = '0;
                        end else begin
                            lit_d = 1'b1;
                            cnt_d = cnt_inc;
                        end
                    end
                end
                default: begin  // MODE_PULSE: only a rising edge matters
                    if (signal && !sig_q) begin
                        state_d = HOLD;
                        lit_d   = 1'b1;
                        cnt_d   = '0;
                    end else if (state_q == HOLD) begin
                        if (cnt_q == period) begin
                            state_d = IDLE;
                            lit_d   = 1'b0;
                            cnt_d   = '0;
                        end else begin
                            lit_d = 1'b1;
                            cnt_d = cnt_inc;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lit_q   <= 1'b0;
            sig_q   <= 1'b0;
            // Track the live mode so leaving reset does not look like a mode change.
            mode_q  <= mode;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lit_q   <= lit_d;
            sig_q   <= sig_d;
            mode_q  <= mode_d;
        end
    end

    assign lit = lit_q;
endmodule

module led_flash_multi #(
    parameter int CHANNELS   = 4,
    parameter int CNT_W      = 25,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [CHANNELS-1:0]   signal,
    input  logic [2*CHANNELS-1:0] mode,
    input  logic [CNT_W-1:0]      period,
    input  logic [CNT_W-1:0]      blink_half,
    output logic [CHANNELS-1:0]   LED
);
    logic [CHANNELS-1:0] lit;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        led_flash_chan #(.CNT_W(CNT_W)) u_chan (
            .clock      (clock),
            .reset      (reset),
            .signal     (signal[g]),
            .mode       (mode[2*g+1:2*g]),
            .period     (period),
            .blink_half (blink_half),
            .lit        (lit[g])
        );
    end

    assign LED = lit ^ {CHANNELS{ACTIVE_LOW}};
endmodule
